// File: rtl/imm_encoder.sv
// imm_encoder: packs a format code, register/function fields and a 32-bit
// signed immediate into an RV32I instruction word. Illegal immediates or
// formats are rejected with an error pulse. An out-of-range `li` (ADDI from x0)
// can be expanded into a LUI+ADDI pair. Each emitted word gets the next
// sequential word address, starting at BASE_ADDR.
//
// Ports:
//   clk, rstn                  clock, async active-low reset
//   in_valid/in_ready          request handshake
//   fmt                        one-hot format: SHAMT,I,S,B,U,J (bit 5..0)
//   opcode,rd,rs1,rs2,funct3,funct7,imm  request fields
//   out_valid/out_ready        output handshake
//   out_instr, out_addr        encoded word and its address
//   err_valid                  one-cycle pulse per rejected request
//   err_cnt                    saturating count of rejected requests
module imm_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          LI_EXPAND = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_valid,
  output logic [7:0]  err_cnt
);

  localparam logic [5:0] F_SHAMT = 6'b100000;
  localparam logic [5:0] F_I     = 6'b010000;
  localparam logic [5:0] F_S     = 6'b001000;
  localparam logic [5:0] F_B     = 6'b000100;
  localparam logic [5:0] F_U     = 6'b000010;
  localparam logic [5:0] F_J     = 6'b000001;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic {IDLE, EMIT_LO} state_t;
  state_t state, state_d;

  logic [11:0] lo_q;
  logic [4:0]  rd_q;

  logic        out_fire, accept;
  logic        i_ok, sh_ok, b_ok, u_ok, j_ok;
  logic        is_li, bad;
  logic [19:0] hi;
  logic [31:0] word;

  assign out_fire = out_valid && out_ready;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Range checks: a signed value fits in N bits when all bits above N-1 match.
  assign i_ok  = (imm[31:11] == {21{imm[31]}});
  assign sh_ok = (imm[31:5] == 27'd0);
  assign b_ok  = (imm[31:12] == {20{imm[31]}}) && !imm[0];
  assign u_ok  = (imm[11:0] == 12'd0);
  assign j_ok  = (imm[31:20] == {12{imm[31]}}) && !imm[0];

  assign is_li = LI_EXPAND && (fmt == F_I) && (opcode == OP_IMM) &&
                 (funct3 == 3'b000) && (rs1 == 5'd0) && !i_ok;

  // Upper part rounds so that the sign-extended low 12 bits add back to imm:
  // (imm + 0x800) >> 12, where the carry out of bit 11 is just imm[11].
  assign hi = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    word = 32'd0;
    bad  = 1'b0;
    case (fmt)
      F_SHAMT: begin
        word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        bad  = !sh_ok;
      end
      F_I: begin
        if (is_li) word = {hi, rd, OP_LUI};
        else       word = {imm[11:0], rs1, funct3, rd, opcode};
        bad = !i_ok && !is_li;
      end
      F_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        bad  = !i_ok;
      end
      F_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        bad  = !b_ok;
      end
      F_U: begin
        word = {imm[31:12], rd, opcode};
        bad  = !u_ok;
      end
      F_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        bad  = !j_ok;
      end
      default: bad = 1'b1;  // zero or multiple bits set
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && is_li && (imm[11:0] != 12'd0)) state_d = EMIT_LO;
      EMIT_LO: if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_addr  <= BASE_ADDR;
      err_valid <= 1'b0;
      err_cnt   <= 8'd0;
      lo_q      <= 12'd0;
      rd_q      <= 5'd0;
    end else begin
      err_valid <= 1'b0;
      // out_addr tracks the address of the word currently (or next) presented.
      if (out_fire) out_addr <= out_addr + 32'd4;
      if (state == EMIT_LO) begin
        // LUI is still presented; swap in the ADDI once it is taken.
        if (out_fire) out_instr <= {lo_q, rd_q, 3'b000, rd_q, OP_IMM};
      end else if (accept) begin
        if (bad) begin
          err_valid <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          if (out_fire) out_valid <= 1'b0;
        end else begin
          out_valid <= 1'b1;
          out_instr <= word;
          lo_q      <= imm[11:0];
          rd_q      <= rd;
        end
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate extender: takes a format code, register/function fields and a 32-bit signed immediate, range-checks the immediate, and packs it into a RISC-V RV32I instruction word.
- Used by the boot/instruction-memory loader and by test generators to stream encoded instructions into IMEM.
- Optionally expands an out-of-range `li` (ADDI rd,x0,imm) into a LUI+ADDI pair via a 2-state FSM.
- Assigns sequential word addresses to emitted instructions.

Parameters:
- BASE_ADDR, 32'h0000_0000, address of the first emitted instruction.
- LI_EXPAND, 1, 1 = expand out-of-range ADDI-from-x0 into LUI+ADDI; 0 = flag as error.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- fmt  in  6  format, one-hot: ITYPE_SHAMT=100000, ITYPE=010000, STYPE=001000, BTYPE=000100, UTYPE=000010, JTYPE=000001
- opcode  in  7  instr[6:0]
- rd  in  5  destination register
- rs1  in  5  source 1
- rs2  in  5  source 2
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]; used only for ITYPE_SHAMT
- imm  in  32  signed byte-level immediate
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- out_instr  out  32  encoded instruction
- out_addr  out  32  address of out_instr
- err_valid  out  1  one-cycle pulse: request rejected
- err_cnt  out  8  saturating count of rejected requests

Behaviour:
- Reset (rstn low, async): state=IDLE, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_valid=0, err_cnt=0. Pending expansion is discarded.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Output is a single register; latency is 1 cycle from acceptance to out_valid.
- Packing and legal imm ranges:
  - ITYPE: {imm[11:0],rs1,funct3,rd,opcode}; imm in [-2048,2047].
  - ITYPE_SHAMT: {funct7,imm[4:0],rs1,funct3,rd,opcode}; imm in [0,31].
  - STYPE: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; imm in [-2048,2047].
  - BTYPE: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; imm in [-4096,4094], imm[0]=0.
  - UTYPE: {imm[31:12],rd,opcode}; requires imm[11:0]=0.
  - JTYPE: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; imm in [-2^20,2^20-2], imm[0]=0.
- Error cases:
  - Trigger: imm out of range, misaligned imm, or fmt not exactly one-hot.
  - Response: request consumed, no output word, out_addr unchanged, err_valid=1 on the next cycle, err_cnt+1 (saturates at 255).
- LI expansion:
  - Trigger: LI_EXPAND=1, fmt=ITYPE, opcode=0010011, funct3=000, rs1=0, imm outside [-2048,2047].
  - hi=(imm+32'h800)[31:12], lo=imm[11:0].
  - Cycle 1: emit LUI {hi,rd,0110111}.
  - If lo!=0: state=EMIT_LO; after the LUI handshake, emit ADDI {lo,rd,000,rd,0010011}, then return to IDLE.
  - If lo==0: LUI only, stay IDLE.
  - in_ready=0 throughout EMIT_LO.
- out_addr increments by 4 on every out_valid&&out_ready; wraps modulo 2^32.
- Backpressure: while out_valid && !out_ready, out_instr/out_addr hold stable.
- Simultaneous events:
  - An output handshake and a new acceptance in the same cycle: the new word loads and out_addr advances by 4.
  - err_valid may coincide with a pending out_valid.
- rd=0 is encoded as given; no special case.

Test Plan:
- ITYPE opcode=0010011 rd=5 rs1=0 f3=0 imm=5, out_ready=1 -> one cycle later out_instr=0x00500293, out_addr=BASE_ADDR.
- LI rd=5 rs1=0 imm=0x12345FFF -> 0x123462B7 at BASE, then 0xFFF28293 at BASE+4; in_ready=0 between the two words.
- BTYPE opcode=1100011 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; JTYPE opcode=1101111 rd=1 imm=8 -> 0x008000EF at next address.
- BTYPE imm=3; then UTYPE imm=0x1001; then fmt=000011 -> three err_valid pulses, err_cnt=3, no out_valid, out_addr unchanged.
- Hold out_ready=0 for 5 cycles with out_valid=1 -> out_instr/out_addr stable, in_ready=0; release -> handshake, out_addr+4.
- Assert rstn low during EMIT_LO -> immediately out_valid=0, err_cnt=0, out_addr=BASE_ADDR; after release in_ready=1 and no ADDI is emitted.
